// File: rtl/vga_pkg.sv
// Shared VGA constants: default 640x480@60 timing, coordinate/colour widths and
// the bundle of per-pixel sync flags that travels through the delay pipeline.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int HCNT_W  = 11;
  localparam int VCNT_W  = 10;
  localparam int COLOR_W = 2;

  localparam int H_TOTAL_MAX = 1 << HCNT_W;
  localparam int V_TOTAL_MAX = 1 << VCNT_W;
  localparam int DLY_MAX     = 4;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
  } sync_t;

  // True when lo <= val < lo+len; used for the sync pulses and the visible area.
  function automatic logic in_window(input int val, input int lo, input int len);
    return (val >= lo) && (val < lo + len);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bus: the pixel enable into the generator and the coordinate,
// sync and strobe outputs consumed by the colour generator and the VGA pins.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic              pix_ce;
  logic [HCNT_W-1:0] hcount;
  logic [VCNT_W-1:0] vcount;
  logic              active;
  logic              hsync;
  logic              vsync;
  logic              line_start;
  logic              frame_start;
  logic              hsync_d;
  logic              vsync_d;
  logic              active_d;

  modport master (
    input  pix_ce,
    output hcount, vcount, active, hsync, vsync,
    output line_start, frame_start, hsync_d, vsync_d, active_d
  );

  modport slave (
    output pix_ce,
    input  hcount, vcount, active, hsync, vsync,
    input  line_start, frame_start, hsync_d, vsync_d, active_d
  );

endinterface

// File: rtl/vga_sig_delay.sv
// DLY-stage shift register for the sync/active bundle; it runs on every clk so
// the delayed syncs track the colour generator's per-clk output register.
module vga_sig_delay
  import vga_pkg::*;
#(
  parameter int    DLY     = 1,
  parameter sync_t RST_VAL = '0
) (
  input  logic  clk,
  input  logic  rst,
  input  sync_t d,
  output sync_t q
);

  sync_t stages [DLY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DLY; i++) stages[i] <= RST_VAL;
    end else begin
      stages[0] <= d;
      for (int i = 1; i < DLY; i++) stages[i] <= stages[i-1];
    end
  end

  assign q = stages[DLY-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: pixel-enabled h/v counters with registered syncs,
// active flag and line/frame strobes, plus a DLY-clk delayed sync/active copy.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int DLY      = 1
) (
  input logic              clk,
  input logic              rst,
  vga_timing_gen_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > H_TOTAL_MAX) begin : g_bad_h_total
    $error("vga_timing_gen: H_TOTAL %0d exceeds %0d", H_TOTAL, H_TOTAL_MAX);
  end
  if (V_TOTAL > V_TOTAL_MAX) begin : g_bad_v_total
    $error("vga_timing_gen: V_TOTAL %0d exceeds %0d", V_TOTAL, V_TOTAL_MAX);
  end
  if (DLY < 1 || DLY > DLY_MAX) begin : g_bad_dly
    $error("vga_timing_gen: DLY %0d outside 1..%0d", DLY, DLY_MAX);
  end

  localparam logic [HCNT_W-1:0] H_LAST = HCNT_W'(H_TOTAL - 1);
  localparam logic [VCNT_W-1:0] V_LAST = VCNT_W'(V_TOTAL - 1);

  // Reset parks on the last back-porch pixel so the first enabled clk lands on (0,0).
  localparam sync_t SYNC_IDLE = '{hsync: ~HS_POL, vsync: ~VS_POL, active: 1'b0};

  logic [HCNT_W-1:0] hcount_q, h_next;
  logic [VCNT_W-1:0] vcount_q, v_next;
  sync_t             sync_q, sync_next, sync_d;
  logic              line_start_q, frame_start_q;

  always_comb begin
    h_next = hcount_q;
    v_next = vcount_q;
    if (bus.pix_ce) begin
      if (hcount_q == H_LAST) begin
        h_next = '0;
        v_next = (vcount_q == V_LAST) ? '0 : vcount_q + VCNT_W'(1);
      end else begin
        h_next = hcount_q + HCNT_W'(1);
      end
    end
  end

  // Flags are decoded from the next coordinate so they register alongside it.
  always_comb begin
    sync_next        = SYNC_IDLE;
    sync_next.hsync  = in_window(int'(h_next), H_ACTIVE + H_FP, H_SYNC) ? HS_POL : ~HS_POL;
    sync_next.vsync  = in_window(int'(v_next), V_ACTIVE + V_FP, V_SYNC) ? VS_POL : ~VS_POL;
    sync_next.active = in_window(int'(h_next), 0, H_ACTIVE) &&
                       in_window(int'(v_next), 0, V_ACTIVE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_q      <= H_LAST;
      vcount_q      <= V_LAST;
      sync_q        <= SYNC_IDLE;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= h_next;
      vcount_q      <= v_next;
      sync_q        <= sync_next;
      line_start_q  <= bus.pix_ce && (h_next == '0);
      frame_start_q <= bus.pix_ce && (h_next == '0) && (v_next == '0);
    end
  end

  vga_sig_delay #(
    .DLY     (DLY),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .clk (clk),
    .rst (rst),
    .d   (sync_q),
    .q   (sync_d)
  );

  assign bus.hcount      = hcount_q;
  assign bus.vcount      = vcount_q;
  assign bus.active      = sync_q.active;
  assign bus.hsync       = sync_q.hsync;
  assign bus.vsync       = sync_q.vsync;
  assign bus.line_start  = line_start_q;
  assign bus.frame_start = frame_start_q;
  assign bus.hsync_d     = sync_d.hsync;
  assign bus.vsync_d     = sync_d.vsync;
  assign bus.active_d    = sync_d.active;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a default 640x480 instance for line-level
// behaviour and a tiny-raster instance (HS_POL=1, DLY=3) for whole-frame behaviour.
module tb_vga_timing_gen;
  import vga_pkg::*;

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic act, hs, vs, ls, fs, hsd, vsd, actd;
  } obs_t;

  // Index 0 = default instance, index 1 = small instance.
  localparam int HA   [2] = '{640, 8};
  localparam int HF   [2] = '{16, 2};
  localparam int HSW  [2] = '{96, 3};
  localparam int HB   [2] = '{48, 2};
  localparam int VA   [2] = '{480, 4};
  localparam int VF   [2] = '{10, 1};
  localparam int VSW  [2] = '{2, 2};
  localparam int VB   [2] = '{33, 2};
  localparam int DLYS [2] = '{1, 3};
  localparam bit HP   [2] = '{1'b0, 1'b1};
  localparam bit VP   [2] = '{1'b0, 1'b0};

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vga_timing_gen_if mbus ();
  vga_timing_gen_if sbus ();

  vga_timing_gen dut_main (
    .clk (clk),
    .rst (rst),
    .bus (mbus)
  );

  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (2),
    .HS_POL   (1'b1), .VS_POL (1'b0), .DLY (3)
  ) dut_small (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  int checks = 0;
  int passes = 0;

  int         m_h [2];
  int         m_v [2];
  logic [2:0] hist [2][4];
  obs_t       exp_q0 [$];
  obs_t       exp_q1 [$];

  function automatic int ht(input int i);
    return HA[i] + HF[i] + HSW[i] + HB[i];
  endfunction

  function automatic int vt(input int i);
    return VA[i] + VF[i] + VSW[i] + VB[i];
  endfunction

  function automatic logic [2:0] aligned(input int i, input int h, input int v);
    logic hs, vs, act;
    hs  = (h >= HA[i] + HF[i] && h < HA[i] + HF[i] + HSW[i]) ? HP[i] : ~HP[i];
    vs  = (v >= VA[i] + VF[i] && v < VA[i] + VF[i] + VSW[i]) ? VP[i] : ~VP[i];
    act = (h < HA[i]) && (v < VA[i]);
    return {hs, vs, act};
  endfunction

  function automatic obs_t obs_main();
    return {mbus.hcount, mbus.vcount, mbus.active, mbus.hsync, mbus.vsync,
            mbus.line_start, mbus.frame_start, mbus.hsync_d, mbus.vsync_d, mbus.active_d};
  endfunction

  function automatic obs_t obs_small();
    return {sbus.hcount, sbus.vcount, sbus.active, sbus.hsync, sbus.vsync,
            sbus.line_start, sbus.frame_start, sbus.hsync_d, sbus.vsync_d, sbus.active_d};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_h[i] = ht(i) - 1;
      m_v[i] = vt(i) - 1;
      for (int k = 0; k < 4; k++) hist[i][k] = {~HP[i], ~VP[i], 1'b0};
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // Advances one instance's reference raster by one clk and returns what it must show.
  task automatic advance(input int i, input bit ce, output obs_t e);
    logic [2:0] a;
    bit         ls;
    if (ce) begin
      if (m_h[i] == ht(i) - 1) begin
        m_h[i] = 0;
        m_v[i] = (m_v[i] == vt(i) - 1) ? 0 : m_v[i] + 1;
      end else begin
        m_h[i] = m_h[i] + 1;
      end
    end
    ls = ce && (m_h[i] == 0);
    a  = aligned(i, m_h[i], m_v[i]);
    e.h = 11'(m_h[i]);
    e.v = 10'(m_v[i]);
    {e.hs, e.vs, e.act} = a;
    e.ls = ls;
    e.fs = ls && (m_v[i] == 0);
    {e.hsd, e.vsd, e.actd} = hist[i][DLYS[i]-1];
    for (int k = 3; k > 0; k--) hist[i][k] = hist[i][k-1];
    hist[i][0] = a;
  endtask

  task automatic drive_main(input bit ce);
    obs_t e;
    mbus.pix_ce = ce;
    advance(0, ce, e);
    exp_q0.push_back(e);
  endtask

  task automatic drive_small(input bit ce);
    obs_t e;
    sbus.pix_ce = ce;
    advance(1, ce, e);
    exp_q1.push_back(e);
  endtask

  task automatic test_reset();
    obs_t o, e;
    rst = 1'b1;
    mbus.pix_ce = 1'b1;
    sbus.pix_ce = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    o = obs_main();
    e = '{h: 11'd799, v: 10'd524, act: 1'b0, hs: 1'b1, vs: 1'b1, ls: 1'b0, fs: 1'b0,
          hsd: 1'b1, vsd: 1'b1, actd: 1'b0};
    checks++;
    if (o !== e)
      $display("[TB] FAIL reset_state: got h=%0d v=%0d flags=%b, want h=%0d v=%0d flags=%b",
               o.h, o.v, o[7:0], e.h, e.v, e[7:0]);
    else passes++;

    rst = 1'b0;
    drive_main(1'b1);
    @(posedge clk);
    #1;
    o = obs_main();
    e = exp_q0.pop_front();
    checks++;
    if (o !== e)
      $display("[TB] FAIL first_pixel_model: got h=%0d v=%0d flags=%b, want h=%0d v=%0d flags=%b",
               o.h, o.v, o[7:0], e.h, e.v, e[7:0]);
    else passes++;
    e = '{h: 11'd0, v: 10'd0, act: 1'b1, hs: 1'b1, vs: 1'b1, ls: 1'b1, fs: 1'b1,
          hsd: 1'b1, vsd: 1'b1, actd: 1'b0};
    checks++;
    if (o !== e)
      $display("[TB] FAIL first_pixel: got h=%0d v=%0d flags=%b, want h=%0d v=%0d flags=%b",
               o.h, o.v, o[7:0], e.h, e.v, e[7:0]);
    else passes++;
  endtask

  task automatic test_lines();
    obs_t o, e;
    int   hs_low = 0;
    int   act_cnt = 0;
    for (int n = 0; n < 7 * 800 - 1; n++) begin
      drive_main(1'b1);
      @(posedge clk);
      #1;
      o = obs_main();
      e = exp_q0.pop_front();
      checks++;
      if (o !== e)
        $display("[TB] FAIL raster: got h=%0d v=%0d flags=%b, want h=%0d v=%0d flags=%b",
                 o.h, o.v, o[7:0], e.h, e.v, e[7:0]);
      else passes++;
      if (e.v == 10'd3 && o.hs == 1'b0) hs_low++;
      if (e.v == 10'd3 && o.act == 1'b1) act_cnt++;
      if (e.h == 11'd0 && e.v == 10'd6) begin
        checks++;
        if (o.h !== 11'd0 || o.v !== 10'd6 || o.ls !== 1'b1 || o.fs !== 1'b0)
          $display("[TB] FAIL line_wrap: got h=%0d v=%0d ls=%b fs=%b, want h=0 v=6 ls=1 fs=0",
                   o.h, o.v, o.ls, o.fs);
        else passes++;
      end
    end
    checks++;
    if (hs_low !== 96)
      $display("[TB] FAIL hsync_width: got %0d low pixels, want 96", hs_low);
    else passes++;
    checks++;
    if (act_cnt !== 640)
      $display("[TB] FAIL active_width: got %0d active pixels, want 640", act_cnt);
    else passes++;
  endtask

  task automatic test_sparse_ce();
    obs_t o, e;
    int   ls_cnt = 0;
    int   hold5 = 0;
    for (int k = 0; k < 3200; k++) begin
      drive_main(k % 4 == 3);
      @(posedge clk);
      #1;
      o = obs_main();
      e = exp_q0.pop_front();
      checks++;
      if (o !== e)
        $display("[TB] FAIL sparse: got h=%0d v=%0d flags=%b, want h=%0d v=%0d flags=%b",
                 o.h, o.v, o[7:0], e.h, e.v, e[7:0]);
      else passes++;
      if (o.ls === 1'b1) ls_cnt++;
      if (e.v == 10'd7 && o.h === 11'd5) hold5++;
    end
    checks++;
    if (ls_cnt !== 1)
      $display("[TB] FAIL sparse_line_start: got %0d pulses, want 1", ls_cnt);
    else passes++;
    checks++;
    if (hold5 !== 4)
      $display("[TB] FAIL sparse_hold: got %0d clks at hcount 5, want 4", hold5);
    else passes++;
  endtask

  task automatic test_mid_reset();
    obs_t o, e, r;
    r = '{h: 11'd799, v: 10'd524, act: 1'b0, hs: 1'b1, vs: 1'b1, ls: 1'b0, fs: 1'b0,
          hsd: 1'b1, vsd: 1'b1, actd: 1'b0};
    for (int n = 0; n < 300; n++) begin
      drive_main(1'b1);
      @(posedge clk);
      #1;
      o = obs_main();
      e = exp_q0.pop_front();
      checks++;
      if (o !== e)
        $display("[TB] FAIL pre_reset: got h=%0d v=%0d flags=%b, want h=%0d v=%0d flags=%b",
                 o.h, o.v, o[7:0], e.h, e.v, e[7:0]);
      else passes++;
    end
    #2;
    rst = 1'b1;
    #1;
    o = obs_main();
    checks++;
    if (o !== r)
      $display("[TB] FAIL async_reset: got h=%0d v=%0d flags=%b, want h=%0d v=%0d flags=%b",
               o.h, o.v, o[7:0], r.h, r.v, r[7:0]);
    else passes++;
    model_reset();
    @(posedge clk);
    #1;
    o = obs_main();
    checks++;
    if (o !== r)
      $display("[TB] FAIL reset_hold: got h=%0d v=%0d flags=%b, want h=%0d v=%0d flags=%b",
               o.h, o.v, o[7:0], r.h, r.v, r[7:0]);
    else passes++;
    rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      drive_main(1'b1);
      @(posedge clk);
      #1;
      o = obs_main();
      e = exp_q0.pop_front();
      checks++;
      if (o !== e)
        $display("[TB] FAIL restart: got h=%0d v=%0d flags=%b, want h=%0d v=%0d flags=%b",
                 o.h, o.v, o[7:0], e.h, e.v, e[7:0]);
      else passes++;
      if (n == 0) begin
        checks++;
        if (o.h !== 11'd0 || o.v !== 10'd0 || o.fs !== 1'b1 || o.ls !== 1'b1)
          $display("[TB] FAIL restart_origin: got h=%0d v=%0d fs=%b ls=%b, want h=0 v=0 fs=1 ls=1",
                   o.h, o.v, o.fs, o.ls);
        else passes++;
      end
    end
  endtask

  task automatic test_frame_wrap();
    obs_t o, e;
    int   last_fs = -1;
    int   period = 0;
    int   vs_low = 0;
    rst = 1'b1;
    mbus.pix_ce = 1'b0;
    sbus.pix_ce = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    o = obs_small();
    e = '{h: 11'd14, v: 10'd8, act: 1'b0, hs: 1'b0, vs: 1'b1, ls: 1'b0, fs: 1'b0,
          hsd: 1'b0, vsd: 1'b1, actd: 1'b0};
    checks++;
    if (o !== e)
      $display("[TB] FAIL small_reset: got h=%0d v=%0d flags=%b, want h=%0d v=%0d flags=%b",
               o.h, o.v, o[7:0], e.h, e.v, e[7:0]);
    else passes++;
    rst = 1'b0;
    for (int n = 0; n < 2 * 135 + 10; n++) begin
      drive_small(1'b1);
      @(posedge clk);
      #1;
      o = obs_small();
      e = exp_q1.pop_front();
      checks++;
      if (o !== e)
        $display("[TB] FAIL small_raster: got h=%0d v=%0d flags=%b, want h=%0d v=%0d flags=%b",
                 o.h, o.v, o[7:0], e.h, e.v, e[7:0]);
      else passes++;
      if (o.fs === 1'b1) begin
        if (last_fs >= 0 && period == 0) period = n - last_fs;
        last_fs = n;
      end
      if (n < 135 && o.vs === 1'b0) vs_low++;
      if (n > 0 && e.h == 11'd0 && e.v == 10'd0) begin
        checks++;
        if (o.fs !== 1'b1 || o.ls !== 1'b1)
          $display("[TB] FAIL frame_wrap: got fs=%b ls=%b, want fs=1 ls=1", o.fs, o.ls);
        else passes++;
      end
    end
    checks++;
    if (period !== 15 * 9)
      $display("[TB] FAIL frame_period: got %0d clks, want %0d", period, 15 * 9);
    else passes++;
    checks++;
    if (vs_low !== 2 * 15)
      $display("[TB] FAIL vsync_width: got %0d low clks, want %0d", vs_low, 2 * 15);
    else passes++;
  endtask

  initial begin
    rst = 1'b1;
    mbus.pix_ce = 1'b0;
    sbus.pix_ce = 1'b0;
    $display("[TB] vga_timing_gen bench start");
    test_reset();
    test_lines();
    test_sparse_ce();
    test_mid_reset();
    test_frame_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing source for the VGA path: generates the hcount/vcount pixel coordinates that the colour-bar generator consumes.
- Also generates hsync/vsync, an active-video flag, and line/frame start strobes.
- Provides a delayed copy of sync/active, so the syncs line up with the colour generator's one-clock registered RGB outputs.
- Sits between the pixel-clock enable logic and the colour generator / VGA pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync asserted level (0 = active-low)
VS_POL, 0, vsync asserted level
DLY, 1, clk cycles of delay on the *_d outputs (range 1..4)

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
pix_ce  in  1  pixel clock enable; counters advance only on clk edges with pix_ce=1
hcount  out  11  current pixel column, 0..H_TOTAL-1
vcount  out  10  current line, 0..V_TOTAL-1
active  out  1  1 when hcount<H_ACTIVE and vcount<V_ACTIVE
hsync  out  1  horizontal sync, aligned with hcount
vsync  out  1  vertical sync, aligned with vcount
line_start  out  1  one-clk pulse on the first clk of hcount=0
frame_start  out  1  one-clk pulse on the first clk of hcount=0, vcount=0
hsync_d  out  1  hsync delayed DLY clks
vsync_d  out  1  vsync delayed DLY clks
active_d  out  1  active delayed DLY clks

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Elaboration-time check: H_TOTAL≤2048, V_TOTAL≤1024, DLY in 1..4.
- Reset (async assert, all outputs registered):
  - hcount=H_TOTAL-1, vcount=V_TOTAL-1, i.e. the last blanking pixel, consistent with back porch.
  - active=0, hsync=~HS_POL, vsync=~VS_POL.
  - line_start=0, frame_start=0.
  - Whole delay pipeline filled with the deasserted values.
- First pix_ce after reset release moves to (0,0): active=1 and frame_start/line_start pulse. Pixel (0,0) is never skipped.
- On a clk with pix_ce=1:
  - hcount increments; hcount=H_TOTAL-1 wraps to 0.
  - On that wrap, vcount increments; vcount=V_TOTAL-1 wraps to 0.
- With pix_ce=0 the counters and the aligned flags hold.
- hsync/vsync/active are registered from the next-count value, so they describe the same coordinate as hcount/vcount in the same cycle (zero relative latency).
- hsync is asserted iff H_ACTIVE+H_FP ≤ hcount < H_ACTIVE+H_FP+H_SYNC (default 656..751).
- vsync is asserted iff V_ACTIVE+V_FP ≤ vcount < V_ACTIVE+V_FP+V_SYNC (default 490..491). vsync changes only with the vcount change at the hcount wrap.
- line_start/frame_start:
  - High for exactly one clk, the clk edge that enters the coordinate.
  - If pix_ce is sparse, a coordinate lasts several clks and the pulse still lasts one clk.
  - frame_start implies line_start.
- *_d outputs form a DLY-stage shift register clocked every clk, not gated by pix_ce, matching the colour generator's per-clk register.
- Reset asserted mid-frame: immediate return to the reset state. Behaviour after release is identical to power-up.
- pix_ce held high continuously: one pixel per clk; frame period = H_TOTAL*V_TOTAL clks.

Decomposition:
- Shared package vga_pkg:
  - Default 640x480@60 timing constants.
  - Derived H_TOTAL/V_TOTAL.
  - Coordinate widths (HCNT_W=11, VCNT_W=10).
  - Colour component width (2).
- One sub-module: vga_sig_delay, a parameterised DLY-stage reset-able shift register instantiated for hsync/vsync/active.

Test Plan:
- Reset, release, pix_ce=1 → during reset hcount=799, vcount=524, active=0, hsync=vsync=1. First clk after release: hcount=0, vcount=0, active=1, frame_start=1, line_start=1.
- Line wrap: hcount 799→0 with vcount 5 → vcount=6, line_start=1, frame_start=0.
- Horizontal sync: hsync=0 exactly for hcount 656..751 on every line. active=0 for hcount≥640.
- Frame wrap: (799,524) → (0,0) with frame_start=1. vsync=0 only for vcount 490..491. Frame length = 420000 clks.
- pix_ce every 4th clk: each coordinate held 4 clks; line_start is high 1 clk of 4. hsync_d equals hsync delayed exactly 1 clk.
- Reset asserted at (300,200) → outputs go to reset values asynchronously. After release, the sequence restarts at (0,0) with frame_start.
